// File: rtl/hex_shift_entry_pkg.sv
// Shared constants, operation encoding and press priority select for the hex entry stage.
// Combinational helpers only; no latency.
// No flow control; presses are dropped, never queued.
package hex_entry_pkg;

    localparam int NDIGITS = 8;
    localparam int NIB_W   = 4;
    localparam int CNT_W   = 4;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_CLEAR,
        OP_SHIFT,
        OP_ROTL,
        OP_ROTR
    } op_t;

    // Coincident presses: clear > shift > rotl > rotr; losers are discarded.
    function automatic op_t sel_op(input logic clear, input logic shift,
                                   input logic rotl, input logic rotr);
        op_t op;
        op = OP_NONE;
        if (clear)      op = OP_CLEAR;
        else if (shift) op = OP_SHIFT;
        else if (rotl)  op = OP_ROTL;
        else if (rotr)  op = OP_ROTR;
        return op;
    endfunction

endpackage

// File: rtl/hex_shift_entry_if.sv
// Front-panel bus: switch nibble and raw buttons in, display value and digit count out.
// Pure wiring; no latency.
// No flow control; buttons are level signals, outputs always valid.
interface hex_shift_entry_if;
    import hex_entry_pkg::*;

    logic [NIB_W-1:0]         sw_data;
    logic                     btn_shift;
    logic                     btn_rotl;
    logic                     btn_rotr;
    logic                     btn_clear;
    logic [NDIGITS*NIB_W-1:0] disp_num;
    logic [CNT_W-1:0]         digit_cnt;
    logic                     full;

    modport master (
        output sw_data, btn_shift, btn_rotl, btn_rotr, btn_clear,
        input  disp_num, digit_cnt, full
    );

    modport slave (
        input  sw_data, btn_shift, btn_rotl, btn_rotr, btn_clear,
        output disp_num, digit_cnt, full
    );
endinterface

// File: rtl/hex_shift_entry_btn_debounce.sv
// Synchronise and debounce one raw button, emit a one-cycle pulse on each accepted press.
// Latency: press rises DB_CNT+3 edges after a stable raw high.
// No backpressure; a press pulse is never held or repeated.
module btn_debounce #(
    parameter int DB_CNT = 500000,
    parameter int DB_W   = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CNT - 1);

    logic            sync_1;
    logic            sync_2;
    logic            acc_lvl;
    logic            acc_lvl_d;
    logic [DB_W-1:0] db_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            acc_lvl   <= 1'b0;
            acc_lvl_d <= 1'b0;
            db_cnt    <= '0;
            press     <= 1'b0;
        end else begin
            sync_1    <= btn_raw;
            sync_2    <= sync_1;
            acc_lvl_d <= acc_lvl;
            press     <= acc_lvl & ~acc_lvl_d;
            // Any cycle where the synced level agrees with the accepted one restarts the count.
            if (sync_2 != acc_lvl) begin
                if (db_cnt == CNT_LAST) begin
                    acc_lvl <= ~acc_lvl;
                    db_cnt  <= '0;
                end else begin
                    db_cnt  <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/hex_shift_entry.sv
// Hex entry register: debounced buttons shift/rotate/clear a 32-bit display value (ENTRY_LOCK_EN blocks shift when full).
// Latency: raw button high before edge 1 updates disp_num at edge DB_CNT+4.
// No backpressure; one operation per cycle, lower-priority coincident presses dropped.
module hex_shift_entry
    import hex_entry_pkg::*;
#(
    parameter int DB_CNT = 500000,
    parameter int DB_W   = 20
) (
    input  logic               clk,
    input  logic               rst,
    hex_shift_entry_if.slave   bus
);

    localparam int DISP_W = NDIGITS * NIB_W;
`ifdef ENTRY_LOCK_EN
    localparam bit LOCK_FULL = 1'b1;
`else
    localparam bit LOCK_FULL = 1'b0;
`endif

    logic              prs_shift;
    logic              prs_rotl;
    logic              prs_rotr;
    logic              prs_clear;
    op_t               op;
    logic [DISP_W-1:0] num_q;
    logic [DISP_W-1:0] num_nxt;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              full_q;

    btn_debounce #(.DB_CNT(DB_CNT), .DB_W(DB_W)) u_db_shift (
        .clk(clk), .rst(rst), .btn_raw(bus.btn_shift), .press(prs_shift));
    btn_debounce #(.DB_CNT(DB_CNT), .DB_W(DB_W)) u_db_rotl (
        .clk(clk), .rst(rst), .btn_raw(bus.btn_rotl), .press(prs_rotl));
    btn_debounce #(.DB_CNT(DB_CNT), .DB_W(DB_W)) u_db_rotr (
        .clk(clk), .rst(rst), .btn_raw(bus.btn_rotr), .press(prs_rotr));
    btn_debounce #(.DB_CNT(DB_CNT), .DB_W(DB_W)) u_db_clear (
        .clk(clk), .rst(rst), .btn_raw(bus.btn_clear), .press(prs_clear));

    assign op = sel_op(prs_clear, prs_shift, prs_rotl, prs_rotr);

    always_comb begin
        num_nxt = num_q;
        cnt_nxt = cnt_q;
        case (op)
            OP_CLEAR: begin
                num_nxt = '0;
                cnt_nxt = '0;
            end
            OP_SHIFT: begin
                if (!(LOCK_FULL && full_q)) begin
                    num_nxt = {num_q[DISP_W-NIB_W-1:0], bus.sw_data};
                    if (cnt_q != CNT_W'(NDIGITS)) cnt_nxt = cnt_q + 1'b1;
                end
            end
            OP_ROTL: num_nxt = {num_q[DISP_W-NIB_W-1:0], num_q[DISP_W-1 -: NIB_W]};
            OP_ROTR: num_nxt = {num_q[NIB_W-1:0], num_q[DISP_W-1:NIB_W]};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            num_q  <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            num_q  <= num_nxt;
            cnt_q  <= cnt_nxt;
            full_q <= (cnt_nxt == CNT_W'(NDIGITS));
        end
    end

    assign bus.disp_num  = num_q;
    assign bus.digit_cnt = cnt_q;
    assign bus.full      = full_q;

endmodule

// File: tb/tb_hex_shift_entry.sv
// Self-checking bench for hex_shift_entry with a short debounce window.
module tb_hex_shift_entry;

    localparam int DB_CNT = 4;
    localparam int DB_W   = 4;
    localparam int HOLD   = DB_CNT + 6;
`ifdef ENTRY_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    // mask bits: 0 shift, 1 rotl, 2 rotr, 3 clear
    typedef struct {
        logic [3:0]  mask;
        logic [3:0]  sw;
        logic [31:0] exp_num;
        logic [3:0]  exp_cnt;
        logic        exp_full;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    hex_shift_entry_if bus ();

    hex_shift_entry #(.DB_CNT(DB_CNT), .DB_W(DB_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_btns(input logic [3:0] mask);
        bus.btn_shift = mask[0];
        bus.btn_rotl  = mask[1];
        bus.btn_rotr  = mask[2];
        bus.btn_clear = mask[3];
    endtask

    task automatic press_btns(input logic [3:0] mask, input logic [3:0] sw);
        bus.sw_data = sw;
        set_btns(mask);
        step(HOLD);
        set_btns(4'h0);
        step(HOLD);
    endtask

    // Reference model: value as plain 32-bit arithmetic, count saturating at 8.
    logic [31:0] m_num;
    int          m_cnt;

    task automatic model_apply(input logic [3:0] mask, input logic [3:0] sw);
        if (mask[3]) begin
            m_num = 0;
            m_cnt = 0;
        end else if (mask[0]) begin
            if (!(LOCK && m_cnt == 8)) begin
                m_num = (m_num << 4) | 32'(sw);
                m_cnt = (m_cnt < 8) ? m_cnt + 1 : 8;
            end
        end else if (mask[1]) begin
            m_num = (m_num << 4) | (m_num >> 28);
        end else if (mask[2]) begin
            m_num = (m_num >> 4) | (m_num << 28);
        end
    endtask

    vec_t tbl[15];

    initial begin
        int          press_cnt;
        int          press_edge;
        logic [3:0]  mask;
        logic [3:0]  sw;

        tbl[0]  = '{4'h8, 4'h0, 32'h00000000, 4'd0, 1'b0};
        tbl[1]  = '{4'h1, 4'h1, 32'h00000001, 4'd1, 1'b0};
        tbl[2]  = '{4'h1, 4'h2, 32'h00000012, 4'd2, 1'b0};
        tbl[3]  = '{4'h1, 4'h3, 32'h00000123, 4'd3, 1'b0};
        tbl[4]  = '{4'h1, 4'h4, 32'h00001234, 4'd4, 1'b0};
        tbl[5]  = '{4'h1, 4'h5, 32'h00012345, 4'd5, 1'b0};
        tbl[6]  = '{4'h1, 4'h6, 32'h00123456, 4'd6, 1'b0};
        tbl[7]  = '{4'h1, 4'h7, 32'h01234567, 4'd7, 1'b0};
        tbl[8]  = '{4'h1, 4'h8, 32'h12345678, 4'd8, 1'b1};
        tbl[9]  = '{4'h2, 4'h0, 32'h23456781, 4'd8, 1'b1};
        tbl[10] = '{4'h4, 4'h0, 32'h12345678, 4'd8, 1'b1};
        tbl[11] = '{4'h4, 4'h0, 32'h81234567, 4'd8, 1'b1};
        tbl[12] = '{4'h2, 4'h0, 32'h12345678, 4'd8, 1'b1};
        tbl[13] = '{4'h1, 4'h9, LOCK ? 32'h12345678 : 32'h23456789, 4'd8, 1'b1};
        tbl[14] = '{4'h9, 4'h7, 32'h00000000, 4'd0, 1'b0};

        rst = 1'b1;
        bus.sw_data = 4'h0;
        set_btns(4'h0);
        step(3);
        chk("reset_disp", bus.disp_num, 32'h0);
        chk("reset_cnt", 32'(bus.digit_cnt), 32'd0);
        chk("reset_full", 32'(bus.full), 32'd0);

        // Latency: button high before edge 1 updates disp_num at edge DB_CNT+4.
        rst = 1'b0;
        bus.sw_data = 4'hA;
        bus.btn_shift = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            step(1);
            if (e == DB_CNT + 3) chk("lat_before", bus.disp_num, 32'h0);
            if (e == DB_CNT + 4) chk("lat_at", bus.disp_num, 32'h0000000A);
        end
        bus.btn_shift = 1'b0;
        step(HOLD);
        chk("lat_single", bus.disp_num, 32'h0000000A);
        chk("lat_cnt", 32'(bus.digit_cnt), 32'd1);

        // Short glitch ignored, then a bouncing press counts once.
        bus.sw_data = 4'h5;
        bus.btn_shift = 1'b1;
        step(2);
        bus.btn_shift = 1'b0;
        step(HOLD);
        chk("glitch_disp", bus.disp_num, 32'h0000000A);
        for (int i = 0; i < 4; i++) begin
            bus.btn_shift = (i % 2 == 0);
            step(1);
        end
        bus.btn_shift = 1'b1;
        step(HOLD);
        bus.btn_shift = 1'b0;
        step(HOLD);
        chk("bounce_disp", bus.disp_num, 32'h000000A5);
        chk("bounce_cnt", 32'(bus.digit_cnt), 32'd2);

        for (int i = 0; i < 15; i++) begin
            press_btns(tbl[i].mask, tbl[i].sw);
            chk($sformatf("tbl%0d_disp", i), bus.disp_num, tbl[i].exp_num);
            chk($sformatf("tbl%0d_cnt", i), 32'(bus.digit_cnt), 32'(tbl[i].exp_cnt));
            chk($sformatf("tbl%0d_full", i), 32'(bus.full), 32'(tbl[i].exp_full));
        end

        m_num = 0;
        m_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            mask = 4'($urandom_range(1, 15));
            if (mask[3] && ($urandom_range(0, 2) != 0)) mask[3] = 1'b0;
            if (mask == 4'h0) mask = 4'h1;
            sw = 4'($urandom);
            press_btns(mask, sw);
            model_apply(mask, sw);
            chk($sformatf("rnd%0d_disp", i), bus.disp_num, m_num);
            chk($sformatf("rnd%0d_cnt", i), 32'(bus.digit_cnt), 32'(m_cnt));
            chk($sformatf("rnd%0d_full", i), 32'(bus.full), 32'(m_cnt == 8));
        end

        // Seed a nonzero value so the reset clear is observable.
        press_btns(4'h1, 4'h3);
        bus.btn_rotl = 1'b1;
        step(3);
        rst = 1'b1;
        step(2);
        chk("midrst_disp", bus.disp_num, 32'h0);
        chk("midrst_cnt", 32'(bus.digit_cnt), 32'd0);
        chk("midrst_full", 32'(bus.full), 32'd0);
        rst = 1'b0;
        press_cnt  = 0;
        press_edge = 0;
        for (int e = 1; e <= 3 * HOLD; e++) begin
            step(1);
            if (dut.u_db_rotl.press) begin
                press_cnt++;
                press_edge = e;
            end
        end
        bus.btn_rotl = 1'b0;
        step(HOLD);
        chk("rst_hold_presses", 32'(press_cnt), 32'd1);
        chk("rst_hold_edge", 32'(press_edge), 32'(DB_CNT + 3));
        chk("rst_hold_disp", bus.disp_num, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
